// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the serial adder/subtractor: FSM encoding and
// helpers that derive the step count and step-counter width from the parameters.
package serial_add_sub_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   function automatic int num_steps(input int width, input int chunk);
      return width / chunk;
   endfunction

   // A single-step configuration still needs a 1-bit counter.
   function automatic int step_cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serial_add_sub_chunk_ripple_adder.sv
// CHUNK-bit ripple-carry adder built from 1-bit full-adder cells; also exposes
// the carry into the top bit so the caller can derive signed overflow.
module chunk_ripple_adder #(
   parameter int CHUNK = 1
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             c_msb_in
);

   logic [CHUNK:0] c;

   always_comb begin
      sum  = '0;
      c    = '0;
      c[0] = cin;
      for (int i = 0; i < CHUNK; i++) begin
         sum[i]   = x[i] ^ y[i] ^ c[i];
         c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
      end
   end

   assign cout     = c[CHUNK];
   assign c_msb_in = c[CHUNK - 1];

endmodule

// File: rtl/serial_add_sub.sv
// Multi-cycle add/subtract: consumes the operands LSB-first, CHUNK bits per
// clock, and publishes sum, carry-out and signed overflow in a one-cycle DONE state.
module serial_add_sub #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf
);

   import serial_add_sub_pkg::*;

   localparam int N  = num_steps(WIDTH, CHUNK);
   localparam int SW = step_cnt_w(N);
   localparam logic [SW-1:0] LAST = SW'(N - 1);

   logic [1:0]       state_q, state_d;
   logic [SW-1:0]    step_q, step_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             co_q, co_d;
   logic             ovf_q, ovf_d;

   logic [CHUNK-1:0] sum_c;
   logic             cout_c;
   logic             c_msb_in_c;
   logic [WIDTH-1:0] acc_next;
   logic             accept;

   chunk_ripple_adder #(
      .CHUNK(CHUNK)
   ) u_adder (
      .x        (a_sh_q[CHUNK-1:0]),
      .y        (b_sh_q[CHUNK-1:0]),
      .cin      (carry_q),
      .sum      (sum_c),
      .cout     (cout_c),
      .c_msb_in (c_msb_in_c)
   );

   // New chunk enters at the top; after N steps the register holds the full result.
   assign acc_next = WIDTH'({sum_c, acc_q} >> CHUNK);
   assign accept   = start && (state_q != RUN);

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      acc_d   = acc_q;
      carry_d = carry_q;
      s_d     = s_q;
      co_d    = co_q;
      ovf_d   = ovf_q;

      case (state_q)
         RUN: begin
            a_sh_d  = a_sh_q >> CHUNK;
            b_sh_d  = b_sh_q >> CHUNK;
            acc_d   = acc_next;
            carry_d = cout_c;
            step_d  = step_q + 1'b1;
            if (step_q == LAST) begin
               state_d = DONE;
               s_d     = acc_next;
               co_d    = cout_c;
               ovf_d   = c_msb_in_c ^ cout_c;
            end
         end
         default: state_d = IDLE;
      endcase

      // Subtraction is a + ~b + 1: invert B and seed the carry with sub.
      if (accept) begin
         state_d = RUN;
         step_d  = '0;
         a_sh_d  = a;
         b_sh_d  = sub ? ~b : b;
         acc_d   = '0;
         carry_d = sub;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         step_q  <= '0;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         s_q     <= '0;
         co_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         acc_q   <= acc_d;
         carry_q <= carry_d;
         s_q     <= s_d;
         co_q    <= co_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign s    = s_q;
   assign co   = co_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Randomized and directed bench for serial_add_sub: one instance bit-serial
// (CHUNK=1), one nibble-serial (CHUNK=4), both checked against an arithmetic model.
module tb_serial_add_sub;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_v [2];
   logic       start_v [2];
   logic       sub_v   [2];
   logic [7:0] a_v     [2];
   logic [7:0] b_v     [2];
   logic       busy_v  [2];
   logic       done_v  [2];
   logic [7:0] s_v     [2];
   logic       co_v    [2];
   logic       ovf_v   [2];

   logic [7:0] held_s   [2];
   logic       held_co  [2];
   logic       held_ovf [2];

   int n_chk  = 0;
   int n_fail = 0;

   serial_add_sub #(.WIDTH(8), .CHUNK(1)) u_c1 (
      .clk(clk), .reset(reset_v[0]), .start(start_v[0]), .sub(sub_v[0]),
      .a(a_v[0]), .b(b_v[0]), .busy(busy_v[0]), .done(done_v[0]),
      .s(s_v[0]), .co(co_v[0]), .ovf(ovf_v[0])
   );

   serial_add_sub #(.WIDTH(8), .CHUNK(4)) u_c4 (
      .clk(clk), .reset(reset_v[1]), .start(start_v[1]), .sub(sub_v[1]),
      .a(a_v[1]), .b(b_v[1]), .busy(busy_v[1]), .done(done_v[1]),
      .s(s_v[1]), .co(co_v[1]), .ovf(ovf_v[1])
   );

   function automatic int steps(input int i);
      return (i == 0) ? 8 : 2;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference result {ovf, co, s} from plain integer arithmetic.
   function automatic logic [9:0] ref_op(input logic [7:0] a, input logic [7:0] b, input logic sub);
      int ua, ub, sa, sb, ures, sres;
      logic [7:0] rs;
      logic rc, ro;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      ures = sub ? (ua - ub) : (ua + ub);
      sres = sub ? (sa - sb) : (sa + sb);
      rs = 8'(ures & 255);
      rc = sub ? (ua >= ub) : (ures > 255);
      ro = (sres > 127) || (sres < -128);
      return {ro, rc, rs};
   endfunction

   task automatic chk_outs(input int i, input string tag, input logic eb, input logic ed,
                           input logic [7:0] es, input logic ec, input logic eo);
      chk($sformatf("d%0d %s busy", i, tag), 32'(busy_v[i]), 32'(eb));
      chk($sformatf("d%0d %s done", i, tag), 32'(done_v[i]), 32'(ed));
      chk($sformatf("d%0d %s s", i, tag), 32'(s_v[i]), 32'(es));
      chk($sformatf("d%0d %s co", i, tag), 32'(co_v[i]), 32'(ec));
      chk($sformatf("d%0d %s ovf", i, tag), 32'(ovf_v[i]), 32'(eo));
   endtask

   task automatic scramble(input int i);
      a_v[i]   = 8'($urandom);
      b_v[i]   = 8'($urandom);
      sub_v[i] = 1'($urandom_range(0, 1));
   endtask

   // Called at a negedge; returns at the negedge of the done cycle with start low,
   // so a caller may chain another op straight into the DONE cycle.
   task automatic op(input int i, input logic [7:0] a, input logic [7:0] b,
                     input logic sub, input int mid);
      logic [9:0] r;
      int n;
      r = ref_op(a, b, sub);
      n = steps(i);
      start_v[i] = 1'b1;
      a_v[i]     = a;
      b_v[i]     = b;
      sub_v[i]   = sub;
      for (int k = 1; k <= n + 1; k++) begin
         @(negedge clk);
         if (k <= n)
            chk_outs(i, $sformatf("op %h%s%h k%0d", a, sub ? "-" : "+", b, k),
                     1'b1, 1'b0, held_s[i], held_co[i], held_ovf[i]);
         else
            chk_outs(i, $sformatf("op %h%s%h done", a, sub ? "-" : "+", b),
                     1'b0, 1'b1, r[7:0], r[8], r[9]);
         scramble(i);
         start_v[i] = (k == mid) && (k <= n);
      end
      held_s[i]   = r[7:0];
      held_co[i]  = r[8];
      held_ovf[i] = r[9];
   endtask

   task automatic idle(input int i, input int cycles);
      for (int k = 0; k < cycles; k++) begin
         start_v[i] = 1'b0;
         @(negedge clk);
         chk_outs(i, $sformatf("idle k%0d", k), 1'b0, 1'b0, held_s[i], held_co[i], held_ovf[i]);
      end
   endtask

   task automatic abort(input int i, input logic [7:0] a, input logic [7:0] b,
                        input logic sub, input int rk);
      start_v[i] = 1'b1;
      a_v[i]     = a;
      b_v[i]     = b;
      sub_v[i]   = sub;
      for (int k = 1; k <= rk; k++) begin
         @(negedge clk);
         chk($sformatf("d%0d abort busy k%0d", i, k), 32'(busy_v[i]), 32'd1);
         scramble(i);
         start_v[i] = 1'b0;
         if (k == rk) reset_v[i] = 1'b1;
      end
      @(negedge clk);
      reset_v[i]  = 1'b0;
      held_s[i]   = 8'h00;
      held_co[i]  = 1'b0;
      held_ovf[i] = 1'b0;
      chk_outs(i, "after abort", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      idle(i, steps(i) + 2);
   endtask

   task automatic reset_and_start(input int i);
      reset_v[i] = 1'b1;
      start_v[i] = 1'b1;
      scramble(i);
      @(negedge clk);
      reset_v[i]  = 1'b0;
      start_v[i]  = 1'b0;
      held_s[i]   = 8'h00;
      held_co[i]  = 1'b0;
      held_ovf[i] = 1'b0;
      chk_outs(i, "reset+start", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      idle(i, 2);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         reset_v[i]  = 1'b1;
         start_v[i]  = 1'b0;
         sub_v[i]    = 1'b0;
         a_v[i]      = 8'h00;
         b_v[i]      = 8'h00;
         held_s[i]   = 8'h00;
         held_co[i]  = 1'b0;
         held_ovf[i] = 1'b0;
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk_outs(i, "reset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
         reset_v[i] = 1'b0;
      end

      // Bit-serial instance: directed cases.
      op(0, 8'h7F, 8'h01, 1'b0, 0);
      idle(0, 2);
      op(0, 8'hFF, 8'h01, 1'b0, 0);
      idle(0, 1);
      op(0, 8'h05, 8'h07, 1'b1, 0);
      idle(0, 1);
      op(0, 8'h3C, 8'h5A, 1'b0, 3);
      idle(0, 2);
      op(0, 8'h11, 8'h22, 1'b1, 0);
      op(0, 8'h10, 8'h20, 1'b0, 0);
      idle(0, 2);
      abort(0, 8'h55, 8'h33, 1'b0, 4);
      op(0, 8'h12, 8'h34, 1'b0, 0);
      idle(0, 1);
      reset_and_start(0);

      // Nibble-serial instance: directed cases.
      op(1, 8'h80, 8'h01, 1'b1, 0);
      idle(1, 2);
      op(1, 8'h7F, 8'h01, 1'b0, 2);
      op(1, 8'h10, 8'h20, 1'b0, 0);
      idle(1, 1);
      abort(1, 8'h9A, 8'h47, 1'b1, 2);
      op(1, 8'hC3, 8'h3D, 1'b1, 0);
      idle(1, 1);
      reset_and_start(1);

      // Random operations, with random ignored mid-run starts and chaining.
      for (int i = 0; i < 2; i++) begin
         for (int t = 0; t < 40; t++) begin
            op(i, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, steps(i))));
            if ($urandom_range(0, 1) == 0) idle(i, int'($urandom_range(1, 2)));
         end
         idle(i, 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
